// File: rtl/single_memory_initiator_pkg.sv
// single_memory_pkg: memory op encodings, grant enum, request bundles
// and the misalignment check shared by the initiator.
package single_memory_pkg;

    localparam logic [2:0] MR_OFF = 3'd0;
    localparam logic [2:0] MR_LW  = 3'd1;
    localparam logic [2:0] MR_LH  = 3'd2;
    localparam logic [2:0] MR_LHU = 3'd3;
    localparam logic [2:0] MR_LB  = 3'd4;
    localparam logic [2:0] MR_LBU = 3'd5;

    localparam logic [1:0] MW_OFF = 2'd0;
    localparam logic [1:0] MW_SW  = 2'd1;
    localparam logic [1:0] MW_SH  = 2'd2;
    localparam logic [1:0] MW_SB  = 2'd3;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_FETCH,
        GNT_DATA
    } gnt_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        step;
    } fetch_req_t;

    typedef struct packed {
        logic [2:0]  read;
        logic [1:0]  write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } data_req_t;

    function automatic logic misaligned(
        input logic [2:0] rd,
        input logic [1:0] wr,
        input logic [1:0] lsb
    );
        logic word;
        logic half;
        word = (rd == MR_LW) || (wr == MW_SW);
        half = (rd == MR_LH) || (rd == MR_LHU) || (wr == MW_SH);
        return (word && (lsb != 2'b00)) || (half && lsb[0]);
    endfunction

endpackage

// File: rtl/single_memory_initiator_hold.sv
// mem_req_hold: one-entry valid/ready holding register. Ports: in_valid/
// in_ready/in_data request side, take = granted this cycle, full/data out.
module mem_req_hold #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         take,
    output logic         full,
    output logic [W-1:0] data
);

    // A granted entry leaves this cycle, so a new one may enter at once.
    assign in_ready = !full || take;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full <= 1'b0;
            data <= '0;
        end else if (in_valid && in_ready) begin
            full <= 1'b1;
            data <= in_data;
        end else if (take) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/single_memory_initiator.sv
// single_memory_initiator: multiplexes fetch and load/store requests onto
// one memory port (one access per cycle) with registered responses.
// Ports: clk, rst (async active-low); if_req_*/if_rsp_* fetch stream;
// dm_req_*/dm_rsp_* data stream; mem_* memory controls and returned data.
// Optional macro STALL_CNT_EN adds if_stall_cnt/dm_stall_cnt outputs.
module single_memory_initiator
    import single_memory_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_BASE = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_pc,
    input  logic        if_step,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_instr,
    input  logic        dm_req_valid,
    output logic        dm_req_ready,
    input  logic [2:0]  dm_req_read,
    input  logic [1:0]  dm_req_write,
    input  logic [31:0] dm_req_addr,
    input  logic [31:0] dm_req_wdata,
    output logic        dm_rsp_valid,
    output logic [31:0] dm_rsp_rdata,
    output logic        dm_rsp_err,
`ifdef STALL_CNT_EN
    output logic [31:0] if_stall_cnt,
    output logic [31:0] dm_stall_cnt,
`endif
    output logic [2:0]  mem_read,
    output logic [1:0]  mem_write,
    output logic [31:0] mem_addr,
    output logic        mem_step,
    output logic [31:0] mem_rs2,
    input  logic [31:0] mem_read_data,
    input  logic [31:0] mem_instr
);

    // ADDR_W counts word-address bits, so the byte span is ADDR_W+2 bits.
    localparam int SPAN = ADDR_W + 2;

    fetch_req_t f_in, f_q;
    data_req_t  d_in, d_q;
    logic       f_full, d_full;
    gnt_t       gnt, last_gnt;
    logic       d_noop, d_err;

    assign f_in = '{pc: if_pc, step: if_step};
    assign d_in = '{read: dm_req_read, write: dm_req_write,
                    addr: dm_req_addr, wdata: dm_req_wdata};

    mem_req_hold #(.W($bits(fetch_req_t))) u_fetch_hold (
        .clk      (clk),
        .rst      (rst),
        .in_valid (if_req_valid),
        .in_ready (if_req_ready),
        .in_data  (f_in),
        .take     (gnt == GNT_FETCH),
        .full     (f_full),
        .data     (f_q)
    );

    mem_req_hold #(.W($bits(data_req_t))) u_data_hold (
        .clk      (clk),
        .rst      (rst),
        .in_valid (dm_req_valid),
        .in_ready (dm_req_ready),
        .in_data  (d_in),
        .take     (gnt == GNT_DATA),
        .full     (d_full),
        .data     (d_q)
    );

    // Round-robin only matters when both streams wait.
    always_comb begin
        gnt = GNT_NONE;
        if (f_full && d_full) begin
            gnt = (last_gnt == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
        end else if (f_full) begin
            gnt = GNT_FETCH;
        end else if (d_full) begin
            gnt = GNT_DATA;
        end
    end

    assign d_noop = (d_q.read == MR_OFF) && (d_q.write == MW_OFF);

    assign d_err = !d_noop && (
        ((d_q.read != MR_OFF) && (d_q.write != MW_OFF)) ||
        (d_q.read > MR_LBU) ||
        misaligned(d_q.read, d_q.write, d_q.addr[1:0]) ||
        (|(d_q.addr >> SPAN)) ||
        (d_q.addr < 32'(DATA_BASE)));

    always_comb begin
        mem_read  = MR_OFF;
        mem_write = MW_OFF;
        mem_addr  = '0;
        mem_step  = 1'b0;
        mem_rs2   = '0;
        unique case (gnt)
            GNT_FETCH: begin
                mem_addr = f_q.pc;
                mem_step = f_q.step;
            end
            GNT_DATA: begin
                if (!d_err) begin
                    mem_addr  = d_q.addr;
                    mem_read  = d_q.read;
                    mem_write = d_q.write;
                    mem_rs2   = d_q.wdata;
                end
            end
            default: ;
        endcase
        // A reset landing before the memory's negedge must not commit a store.
        if (!rst) begin
            mem_write = MW_OFF;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rsp_valid <= 1'b0;
            if_rsp_instr <= '0;
            dm_rsp_valid <= 1'b0;
            dm_rsp_rdata <= '0;
            dm_rsp_err   <= 1'b0;
            last_gnt     <= GNT_DATA;
        end else begin
            if_rsp_valid <= (gnt == GNT_FETCH);
            if_rsp_instr <= (gnt == GNT_FETCH) ? mem_instr : '0;
            dm_rsp_valid <= (gnt == GNT_DATA);
            dm_rsp_err   <= (gnt == GNT_DATA) && d_err;
            dm_rsp_rdata <= ((gnt == GNT_DATA) && !d_err &&
                             (d_q.read != MR_OFF)) ? mem_read_data : '0;
            if (gnt != GNT_NONE) begin
                last_gnt <= gnt;
            end
        end
    end

`ifdef STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_stall_cnt <= '0;
            dm_stall_cnt <= '0;
        end else begin
            if (f_full && (gnt != GNT_FETCH) && (if_stall_cnt != '1)) begin
                if_stall_cnt <= if_stall_cnt + 32'd1;
            end
            if (d_full && (gnt != GNT_DATA) && (dm_stall_cnt != '1)) begin
                dm_stall_cnt <= dm_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
